// File: rtl/regfile_write_scheduler.sv
// Register-file write-port scheduler: clears all 32 registers after reset, then
// arbitrates the single write port between MEM, ALU and DBG writeback requesters.
module regfile_write_scheduler #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        dbg_valid,
  input  logic [4:0]  dbg_addr,
  input  logic [31:0] dbg_data,
  output logic        dbg_ready,
  output logic        registerWrite,
  output logic [4:0]  writeAddress,
  output logic [31:0] writeData,
  output logic        init_done
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic [SW-1:0]   r_starve, w_starve_nxt;
  logic            r_we, w_we_nxt;
  logic [AW-1:0]   r_waddr, w_waddr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic            r_done, w_done_nxt;

  logic            w_run;
  logic            w_force;
  logic            w_gnt_mem, w_gnt_alu, w_gnt_dbg;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  // Grant: MEM > ALU > DBG, unless DBG has been stalled long enough to be forced through
  always_comb begin
    w_gnt_mem  = 1'b0;
    w_gnt_alu  = 1'b0;
    w_gnt_dbg  = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    w_run      = (r_state == S_RUN) && !rst;
    w_force    = dbg_valid && (r_starve >= SW'(STARVE_LIMIT));
    if (w_run) begin
      if (w_force) begin
        w_gnt_dbg = 1'b1;
      end else if (mem_valid) begin
        w_gnt_mem = 1'b1;
      end else if (alu_valid) begin
        w_gnt_alu = 1'b1;
      end else if (dbg_valid) begin
        w_gnt_dbg = 1'b1;
      end
    end
    if (w_gnt_mem) begin
      w_sel_addr = mem_addr;
      w_sel_data = mem_data;
    end else if (w_gnt_alu) begin
      w_sel_addr = alu_addr;
      w_sel_data = alu_data;
    end else if (w_gnt_dbg) begin
      w_sel_addr = dbg_addr;
      w_sel_data = dbg_data;
    end
    w_xfer = w_gnt_mem || w_gnt_alu || w_gnt_dbg;
  end

  assign mem_ready = w_gnt_mem;
  assign alu_ready = w_gnt_alu;
  assign dbg_ready = w_gnt_dbg;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_starve_nxt = r_starve;
    w_we_nxt     = 1'b0;
    w_waddr_nxt  = r_waddr;
    w_wdata_nxt  = r_wdata;
    w_done_nxt   = r_done;
    case (r_state)
      S_INIT: begin
        w_we_nxt     = 1'b1;
        w_waddr_nxt  = r_cnt;
        w_wdata_nxt  = '0;
        w_cnt_nxt    = AW'(r_cnt + 1'b1);
        w_starve_nxt = '0;
        if (r_cnt == AW'(31)) begin
          w_state_nxt = S_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (w_xfer) begin
          // Register 0 is hardwired zero: accept the request but suppress the write
          w_we_nxt    = (w_sel_addr != '0);
          w_waddr_nxt = w_sel_addr;
          w_wdata_nxt = w_sel_data;
        end
        if (dbg_valid && !w_gnt_dbg) begin
          w_starve_nxt = (r_starve == '1) ? r_starve : SW'(r_starve + 1'b1);
        end else begin
          w_starve_nxt = '0;
        end
      end
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_INIT;
      r_cnt    <= '0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
      r_we     <= w_we_nxt;
      r_waddr  <= w_waddr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign registerWrite = r_we;
  assign writeAddress  = r_waddr;
  assign writeData     = r_wdata;
  assign init_done     = r_done;

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the processor register file and schedules writes into it.
- After reset, sequences a 32-cycle clear of all registers before any other write is accepted.
- In run mode, arbitrates the write port between three writeback requesters: memory load (MEM), ALU result (ALU) and debug/loader (DBG).
- Sits between the writeback stage and the register file write inputs; the read ports are untouched.

Parameters:
- STARVE_LIMIT, 8, consecutive stalled cycles of a pending DBG request after which DBG is forced to win the next arbitration (range 1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- mem_valid  input  1  MEM write request
- mem_addr  input  5  MEM destination register
- mem_data  input  32  MEM write data
- mem_ready  output  1  MEM request accepted this cycle
- alu_valid  input  1  ALU write request
- alu_addr  input  5  ALU destination register
- alu_data  input  32  ALU write data
- alu_ready  output  1  ALU request accepted this cycle
- dbg_valid  input  1  DBG write request
- dbg_addr  input  5  DBG destination register
- dbg_data  input  32  DBG write data
- dbg_ready  output  1  DBG request accepted this cycle
- registerWrite  output  1  write enable to register file
- writeAddress  output  5  write address to register file
- writeData  output  32  write data to register file
- init_done  output  1  high once the clear sweep has completed

Behaviour:
- Reset:
  - Synchronous on the rising clk edge with rst=1.
  - State←INIT, sweep counter←0, starvation counter←0.
  - registerWrite=0, writeAddress=0, writeData=0, init_done=0.
  - All ready outputs are 0 while rst=1.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle, register registerWrite=1, writeAddress=counter, writeData=0; then counter+1.
  - After the cycle that issues address 31, go to RUN.
  - init_done registers to 1 on the same edge that enters RUN.
  - Addresses 0..31 therefore appear on the registered outputs on cycles 1..32 after reset release.
  - All ready outputs are 0 throughout INIT.
- RUN arbitration (combinational grant):
  - Default priority is MEM > ALU > DBG.
  - Starvation override: when the starvation counter ≥ STARVE_LIMIT and dbg_valid=1, DBG wins over MEM and ALU.
  - Exactly one ready is asserted: the winner's, and only if its valid=1. A transfer occurs when valid&&ready.
  - Ready does not depend on the requester's own data or address.
  - Requesters hold valid, addr and data stable until ready is seen.
- Output latency:
  - The winner's addr/data are registered onto writeAddress/writeData with registerWrite=1 on the next clk edge (1-cycle latency).
  - With no transfer, registerWrite registers to 0; writeAddress and writeData hold their previous values.
- Address 0:
  - A RUN transfer to addr 0 is accepted normally (ready=1).
  - registerWrite registers to 0 for it, so register 0 stays zero.
  - The INIT sweep does write address 0.
- Starvation counter:
  - Increments (saturating at 255) each RUN cycle where dbg_valid=1 and dbg_ready=0.
  - Clears to 0 on a DBG transfer, and on any cycle with dbg_valid=0.
- Throughput: one write per cycle; there is no internal buffering beyond the output register.
- Reset mid-operation:
  - Any in-flight registered write is dropped; registerWrite=0 the cycle after.
  - The INIT sweep restarts from address 0.
- Simultaneous valids: resolved purely by the priority/override rule above in the same cycle; losers see ready=0 and retry.

Test Plan:
- Reset release, no requests → registerWrite=1 for exactly 32 cycles with writeAddress 0,1,…,31 and writeData=0; init_done=1 from the cycle after address 31; all readies 0 during INIT.
- RUN, mem_valid=alu_valid=1 (mem_addr=5/data=0xAAAA0000, alu_addr=6/data=0x12345678) → cycle n: mem_ready=1 and alu_ready=0; cycle n+1: write 5/0xAAAA0000 and alu_ready=1; cycle n+2: write 6/0x12345678.
- RUN, DBG held valid (addr=9, data=0xDEADBEEF) while MEM is continuously valid, STARVE_LIMIT=8 → dbg_ready=1 on the 9th cycle; next cycle writeAddress=9 and writeData=0xDEADBEEF; the counter then clears.
- RUN, alu_valid=1 with alu_addr=0 and data=0xFFFFFFFF → alu_ready=1; next cycle registerWrite=0.
- Assert rst for 1 cycle midway through a MEM burst → registerWrite=0 the cycle after; the INIT sweep restarts at address 0; mem_ready=0 until init_done=1.
